fifo_reader: RTL and testbench

//  Drain side of the 8-bit synchronous FIFO. Pops words via the FIFO's ren/empty/Dout port and

---
 rtl/fifo_reader_pkg.sv | 26 ++
 rtl/fifo_reader_skid_buf2.sv | 79 +++++++
 rtl/fifo_reader.sv | 82 ++++++++
 tb/tb_fifo_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared constants for fifo_reader: data width, skid buffer state encoding and credit limit.
// The skid state value equals the number of buffered entries.
package fifo_reader_pkg;

    localparam int DW_DEFAULT = 8;

    typedef logic [1:0] skid_state_t;

    localparam skid_state_t SKID_EMPTY = 2'd0;
    localparam skid_state_t SKID_ONE   = 2'd1;
    localparam skid_state_t SKID_TWO   = 2'd2;

    localparam logic [2:0] CREDIT_LIMIT = 3'd2;

    // Words owned after this cycle's transfer, evaluated at 3 bits so it never wraps.
    function automatic logic credit_ok(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       xfer
    );
        logic [2:0] owned;
        owned = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
        return owned < CREDIT_LIMIT;
    endfunction

endpackage

// File: rtl/fifo_reader_skid_buf2.sv
// skid_buf2: 2-entry in-order buffer that captures FIFO read data and drives the valid/ready stream.
// Latency: capture at end of cycle N -> m_valid in N+1; no bypass from cap_dat to m_data.
// Backpressure: holds m_data stable while m_valid & !m_ready; upstream credit keeps it from overfilling.
module skid_buf2
    import fifo_reader_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_vld,
    input  logic [DW-1:0] cap_dat,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ
);

    skid_state_t   state_q, state_d;
    logic [DW-1:0] ent0_q, ent0_d;
    logic [DW-1:0] ent1_q, ent1_d;
    logic          xfer;

    assign m_valid = (state_q != SKID_EMPTY);
    assign m_data  = ent0_q;
    assign occ     = state_q;
    assign xfer    = m_valid & m_ready;

    // ent0 is always the oldest entry; ent1 only holds a word while in TWO.
    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (state_q)
            SKID_EMPTY: begin
                if (cap_vld) begin
                    ent0_d  = cap_dat;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (cap_vld && xfer) begin
                    ent0_d = cap_dat;
                end else if (cap_vld) begin
                    ent1_d  = cap_dat;
                    state_d = SKID_TWO;
                end else if (xfer) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (xfer) begin
                    ent0_d = ent1_q;
                    if (cap_vld) begin
                        ent1_d = cap_dat;
                    end else begin
                        state_d = SKID_ONE;
                    end
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            state_q <= state_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains an 8-bit synchronous FIFO onto a valid/ready stream; FIFO_RD_STATS_EN adds rd_count.
// Latency: pop in cycle N -> m_valid in N+2; sustains 1 word/cycle while m_ready is high.
// Backpressure: at most 2 words owned (buffered + in flight); pops stop once that credit is used up.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DW = DW_DEFAULT
`ifdef FIFO_RD_STATS_EN
    ,
    parameter int CW = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    output logic          fifo_ren,
    input  logic [DW-1:0] fifo_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CW-1:0] rd_count
`endif
);

    logic       inflight_q, inflight_d;
    logic       xfer;
    logic [1:0] occ;

    assign xfer = m_valid & m_ready;

    // A slot freed by this cycle's transfer can be refilled in the same cycle.
    assign fifo_ren = !rst && !fifo_empty && credit_ok(occ, inflight_q, xfer);

    always_comb begin
        inflight_d = fifo_ren & ~fifo_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    skid_buf2 #(
        .DW(DW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .cap_vld (inflight_q),
        .cap_dat (fifo_dout),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .occ     (occ)
    );

`ifdef FIFO_RD_STATS_EN
    logic [CW-1:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        if (xfer) begin
            rd_count_d = rd_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural FIFO in front, scoreboard and ownership monitor behind.
module tb_fifo_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_ren;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          push_vld;
    logic [DW-1:0] push_dat;

    int total = 0;
    int bad = 0;
    int pop_cnt = 0;
    int xfer_cnt = 0;

    logic [DW-1:0] mem[$];
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef FIFO_RD_STATS_EN
    localparam int CW = 4;
    logic [CW-1:0] rd_count;

    fifo_reader #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .rd_count   (rd_count)
    );
`else
    fifo_reader #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous FIFO with one-cycle read latency; every pushed word enters the scoreboard.
    always @(posedge clk or posedge rst) begin : fifo_model
        int n;
        if (rst) begin
            mem.delete();
            exp_q.delete();
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
            pop_cnt = 0;
        end else begin
            n = mem.size();
            if (fifo_ren && !fifo_empty) begin
                fifo_dout <= mem.pop_front();
                n--;
                pop_cnt++;
            end
            if (push_vld) begin
                mem.push_back(push_dat);
                exp_q.push_back(push_dat);
                n++;
            end
            fifo_empty <= (n == 0);
        end
    end

    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_dat = '0;

    always begin : monitor
        @(negedge clk);
        #2;
        if (rst) begin
            xfer_cnt   = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vld", 32'(m_valid), 32'd1);
                chk("hold_dat", 32'(m_data), 32'(stall_dat));
            end
            chk("owned_le2", (pop_cnt - xfer_cnt <= 2) ? 32'd1 : 32'd0, 32'd1);
`ifdef FIFO_RD_STATS_EN
            chk("rd_count", 32'(rd_count), 32'(xfer_cnt % (1 << CW)));
`endif
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("order", 32'(m_data), 32'(exp_q.pop_front()));
                end
                xfer_cnt++;
            end
            stall_prev = m_valid & ~m_ready;
            stall_dat  = m_data;
        end
    end

    task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic rdy);
        @(negedge clk);
        push_vld = pv;
        push_dat = pd;
        m_ready  = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        push_vld = 1'b0;
        m_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            drive(1'b0, '0, 1'b1);
        end
        repeat (3) drive(1'b0, '0, 1'b1);
    endtask

    typedef struct {
        logic          push;
        logic          rdy;
        logic          exp_ren;
        logic          exp_vld;
        logic          chk_dat;
        logic [DW-1:0] exp_dat;
    } vec_t;

    vec_t tbl[15];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int fp, fv, fx, lx, nx, pushed, mode;
        logic rdy, pv;

        // Cycle-by-cycle: 8 words pushed into an idle reader, consumer stalled until cycle 6.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h06};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        rst      = 1'b0;
        push_vld = 1'b0;
        push_dat = '0;
        m_ready  = 1'b0;
        #3 rst = 1'b1;

        // Reset with the FIFO empty: everything idle.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b0);
            #1;
            chk($sformatf("t1_ren[%0d]", i), 32'(fifo_ren), 32'd0);
            chk($sformatf("t1_vld[%0d]", i), 32'(m_valid), 32'd0);
            chk($sformatf("t1_dat[%0d]", i), 32'(m_data), 32'd0);
        end

        // Backpressure table: two pops, held data, same-cycle resume, in-order drain.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].push, 8'(i + 1), tbl[i].rdy);
            #1;
            chk($sformatf("t3_ren[%0d]", i), 32'(fifo_ren), 32'(tbl[i].exp_ren));
            chk($sformatf("t3_vld[%0d]", i), 32'(m_valid), 32'(tbl[i].exp_vld));
            if (tbl[i].chk_dat) begin
                chk($sformatf("t3_dat[%0d]", i), 32'(m_data), 32'(tbl[i].exp_dat));
            end
        end
        drain(20);
        chk("t3_delivered", 32'(xfer_cnt), 32'd8);

        // Streaming 0x01..0x10 with the consumer always ready.
        do_reset();
        fp = -1; fv = -1; fx = -1; lx = -1; nx = 0;
        for (int c = 0; c < 40; c++) begin
            drive(c < 16, 8'(c + 1), 1'b1);
            #1;
            if (fp < 0 && fifo_ren && !fifo_empty) fp = c;
            if (fv < 0 && m_valid) fv = c;
            if (m_valid && m_ready) begin
                if (fx < 0) fx = c;
                lx = c;
                nx++;
            end
        end
        chk("t2_latency", 32'(fv - fp), 32'd2);
        chk("t2_count", 32'(nx), 32'd16);
        chk("t2_back_to_back", 32'(lx - fx), 32'd15);

        // 256 words under patterned and random m_ready and random push gaps.
        do_reset();
        pushed = 0;
        for (int c = 0; c < 4000 && (pushed < 256 || exp_q.size() != 0); c++) begin
            mode = (c / 128) % 4;
            case (mode)
                0:       rdy = (c % 2) == 0;
                1:       rdy = (c % 4) >= 2;
                2:       rdy = ($urandom % 2) == 0;
                default: rdy = ($urandom % 4) != 0;
            endcase
            pv = (pushed < 256) && (($urandom % 4) != 0);
            drive(pv, 8'(pushed * 7 + 3), rdy);
            if (pv) pushed++;
        end
        drain(20);
        chk("t4_pushed", 32'(pushed), 32'd256);
        chk("t4_delivered", 32'(xfer_cnt), 32'd256);
        chk("t4_leftover", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream, then a clean burst.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 8'(8'h50 + c), 1'b1);
        end
        @(negedge clk);
        rst      = 1'b1;
        push_vld = 1'b0;
        #1;
        chk("t5_rst_ren", 32'(fifo_ren), 32'd0);
        chk("t5_rst_vld", 32'(m_valid), 32'd0);
        chk("t5_rst_dat", 32'(m_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 8'(8'hA0 + c), 1'b1);
        end
        drain(20);
        chk("t5_delivered", 32'(xfer_cnt), 32'd4);
        chk("t5_leftover", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_RD_STATS_EN
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 8'(c), 1'b1);
        end
        drain(20);
        chk("t6_rd_count_wrap", 32'(rd_count), 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
